// File: rtl/alu_fx_pkg.sv
// Shared types and saturation helper for the sequential fixed-point ALU.
// fx_clamp works on a 64-bit signed intermediate and narrows it to dw bits.
package alu_fx_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int WIDE_W = 64;

    typedef struct packed {
        logic [WIDE_W-1:0] value;
        logic              ovf;
    } clamp_t;

    // Values outside the dw-bit signed range go to max/min when sat is set;
    // otherwise they pass through and the caller keeps the low dw bits.
    function automatic clamp_t fx_clamp(input logic signed [WIDE_W-1:0] value,
                                        input logic sat, input int dw);
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        clamp_t r;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        r.ovf = (value > max_v) || (value < min_v);
        if (r.ovf && sat) begin
            r.value = (value < 64'sd0) ? min_v : max_v;
        end else begin
            r.value = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/fx_div_iter.sv
// Unsigned restoring divider: one quotient bit per clock over QW iterations.
// done is high during the last iteration; quotient is final after that edge.
module fx_div_iter #(
    parameter int QW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(QW);

    logic [QW-1:0] rem_q;
    logic [QW-1:0] quo_q;
    logic [QW-1:0] div_q;
    logic [CW-1:0] cnt_q;
    logic [QW:0]   shifted;
    logic [QW:0]   diff;
    logic          take;

    // The dividend is shifted out of the quotient register as quotient bits enter.
    assign shifted  = {rem_q, quo_q[QW-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign take     = !diff[QW];
    assign done     = busy && (cnt_q == CW'(QW - 1));
    assign quotient = quo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt_q <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            rem_q <= take ? diff[QW-1:0] : shifted[QW-1:0];
            quo_q <= {quo_q[QW-2:0], take};
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_fixedpoint_seq.sv
// Sequential Q(INT_BITS).(FRAC_BITS) ALU with saturate/wrap and N/V/Z/DZ flags.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
module alu_fixedpoint_seq
    import alu_fx_pkg::*;
#(
    parameter int  INT_BITS   = 7,
    parameter int  FRAC_BITS  = 8,
    localparam int DATA_WIDTH = 1 + INT_BITS + FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [1:0]            opcode,
    input  logic                  sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag_n,
    output logic                  flag_v,
    output logic                  flag_z,
    output logic                  flag_dz,
    output state_e                dbg_state
);
    localparam int QW  = DATA_WIDTH + FRAC_BITS;
    localparam int MSB = DATA_WIDTH - 1;

    state_e state, state_next;
    logic   pend;
    logic [MSB:0] a_q, b_q;
    op_e    op_q;
    logic   sat_q;
    logic   accept, div_start, out_free, load;
    logic   div_busy, div_done;
    logic [QW-1:0] quotient;
    logic [MSB:0]  abs_a, abs_b;
    logic signed [2*DATA_WIDTH-1:0] a_x, b_x, prod;
    logic signed [WIDE_W-1:0] a_w, b_w, prod_w, quo_w, wide;
    clamp_t cl;
    logic [MSB:0] res_next;
    logic v_next, dz_next;
    logic unused_hi;

    assign dbg_state = state;
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && !div_busy && out_free;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op_e'(opcode) == OP_DIV) && (b != '0);
    // pend marks a latched single-cycle op (or div by zero) awaiting the output slot.
    assign load      = out_free && (pend || state == FIN);

    assign abs_a = a[MSB] ? -a : a;
    assign abs_b = b[MSB] ? -b : b;

    fx_div_iter #(.QW(QW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({abs_a, {FRAC_BITS{1'b0}}}),
        .divisor  ({{FRAC_BITS{1'b0}}, abs_b}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_start) state_next = DIV;
            DIV:     if (div_done) state_next = FIN;
            FIN:     if (out_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            sat_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op_e'(opcode);
                sat_q <= sat;
                pend  <= !div_start;
            end else if (pend && out_free) begin
                pend <= 1'b0;
            end
        end
    end

    assign a_x    = {{DATA_WIDTH{a_q[MSB]}}, a_q};
    assign b_x    = {{DATA_WIDTH{b_q[MSB]}}, b_q};
    assign prod   = a_x * b_x;
    assign a_w    = {{(WIDE_W-DATA_WIDTH){a_q[MSB]}}, a_q};
    assign b_w    = {{(WIDE_W-DATA_WIDTH){b_q[MSB]}}, b_q};
    assign prod_w = {{(WIDE_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign quo_w  = {{(WIDE_W-QW){1'b0}}, quotient};

    always_comb begin
        wide    = '0;
        dz_next = 1'b0;
        case (op_q)
            OP_ADD: wide = a_w + b_w;
            OP_SUB: wide = a_w - b_w;
            OP_MUL: wide = prod_w >>> FRAC_BITS;
            OP_DIV: begin
                dz_next = (b_q == '0);
                wide    = (a_q[MSB] ^ b_q[MSB]) ? -quo_w : quo_w;
            end
            default: wide = '0;
        endcase
        cl       = fx_clamp(wide, sat_q, DATA_WIDTH);
        res_next = cl.value[MSB:0];
        v_next   = cl.ovf;
        // Divide by zero saturates toward the sign of a, or yields zero.
        if (dz_next) begin
            v_next = 1'b1;
            if (!sat_q || a_q == '0) begin
                res_next = '0;
            end else if (a_q[MSB]) begin
                res_next = {1'b1, {MSB{1'b0}}};
            end else begin
                res_next = {1'b0, {MSB{1'b1}}};
            end
        end
    end

    assign unused_hi = ^cl.value[WIDE_W-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
            flag_dz   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= res_next;
            flag_n    <= res_next[MSB];
            flag_v    <= v_next;
            flag_z    <= (res_next == '0);
            flag_dz   <= dz_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_fixedpoint_seq.sv
// Scoreboard bench for alu_fixedpoint_seq: expected results come from an integer model of the Q7.8 rules.
module tb_alu_fixedpoint_seq;
    import alu_fx_pkg::*;

    localparam int FRAC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sat = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  opcode = '0;
    logic        in_ready, out_valid, flag_n, flag_v, flag_z, flag_dz;
    logic [15:0] result;
    state_e      dbg_state;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    bit          rand_ready = 0;
    logic [19:0] exp_q[$];
    longint      acc_q[$];
    int          lat_q[$];
    logic [19:0] mon_exp, bp_exp;
    longint      mon_acc;
    int          mon_lat;
    logic [15:0] ra, rb;
    longint      c0;
    int          hi_cnt;
    bit          seen;

    alu_fixedpoint_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_dz   (flag_dz),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {result, n, v, z, dz}.
    function automatic logic [19:0] ref_model(input logic [15:0] ia, input logic [15:0] ib,
                                              input logic [1:0] iop, input logic isat);
        longint sa, sb, w, q, ma, mb;
        logic [15:0] r;
        logic v, dz;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        v = 1'b0;
        dz = 1'b0;
        w = 0;
        case (iop)
            2'd0: w = sa + sb;
            2'd1: w = sa - sb;
            2'd2: w = (sa * sb) >>> FRAC;
            default: begin
                if (sb == 0) begin
                    dz = 1'b1;
                end else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q = (ma * (longint'(1) << FRAC)) / mb;
                    w = ((sa < 0) != (sb < 0)) ? -q : q;
                end
            end
        endcase
        if (dz) begin
            v = 1'b1;
            r = (!isat || sa == 0) ? 16'h0000 : ((sa < 0) ? 16'h8000 : 16'h7FFF);
        end else if (w > 32767 || w < -32768) begin
            v = 1'b1;
            r = isat ? ((w > 0) ? 16'h7FFF : 16'h8000) : w[15:0];
        end else begin
            r = w[15:0];
        end
        return {r, r[15], v, (r == 16'h0000), dz};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                         input logic isat, input int lat, input bit push);
        bit got;
        got = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        opcode = iop;
        sat = isat;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept");
        end else if (push) begin
            exp_q.push_back(ref_model(ia, ib, iop, isat));
            acc_q.push_back(cyc + 1);
            lat_q.push_back(lat);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        opcode = 2'($urandom);
        sat = 1'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", result);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                mon_lat = lat_q.pop_front();
                check("result_flags", 32'({result, flag_n, flag_v, flag_z, flag_dz}), 32'(mon_exp));
                if (mon_lat >= 0) check("latency", 32'(cyc - mon_acc), 32'(mon_lat));
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", 32'({flag_n, flag_v, flag_z, flag_dz}), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(16'h0180, 16'h0240, 2'd0, 1'b1, 1, 1);
        issue(16'h7F00, 16'h0200, 2'd0, 1'b1, 1, 1);
        issue(16'h7F00, 16'h0200, 2'd0, 1'b0, 1, 1);
        issue(16'h0100, 16'h0100, 2'd1, 1'b1, 1, 1);
        issue(16'hFE80, 16'h0200, 2'd2, 1'b1, 1, 1);
        c0 = cyc;
        for (int i = 0; i < 4; i++) issue(16'($urandom), 16'($urandom), 2'd0, 1'($urandom), 1, 1);
        check("throughput_cycles", 32'(cyc - c0), 32'd4);
        drain();

        issue(16'h0300, 16'h0200, 2'd3, 1'b1, 25, 1);
        hi_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) check("div_state", 32'(dbg_state), 32'(DIV));
            if (out_valid) break;
            if (in_ready) hi_cnt++;
        end
        check("div_in_ready_low", 32'(hi_cnt), 32'h0);
        drain();

        issue(16'h8000, 16'hFF00, 2'd3, 1'b1, 25, 1);
        issue(16'h0100, 16'h0000, 2'd3, 1'b1, 1, 1);
        issue(16'h0100, 16'h0000, 2'd3, 1'b0, 1, 1);
        issue(16'h0000, 16'h0000, 2'd3, 1'b1, 1, 1);
        issue(16'hFF00, 16'h0000, 2'd3, 1'b1, 1, 1);
        issue(16'hF000, 16'h0300, 2'd3, 1'b0, 25, 1);
        drain();

        out_ready = 1'b0;
        issue(16'h0123, 16'hFA56, 2'd2, 1'b1, -1, 1);
        bp_exp = ref_model(16'h0123, 16'hFA56, 2'd2, 1'b1);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("bp_out_valid", 32'(seen), 32'h1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_hold", 32'({result, flag_n, flag_v, flag_z, flag_dz}), 32'(bp_exp));
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        issue(16'h0500, 16'h0300, 2'd3, 1'b1, -1, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("abort_state", 32'(dbg_state), 32'(DIV));
        check("abort_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_result", 32'(result), 32'h0);
        check("abort_state_idle", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready_after", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        issue(16'h0180, 16'h0240, 2'd0, 1'b1, 1, 1);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
            rb = ($urandom_range(0, 9) == 0) ? 16'h0000 :
                 (($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024);
            issue(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 1);
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
